// File: rtl/frame_parity_if.sv
// Word-in / result-out handshake bundle for frame_parity.
// The block under test takes the slave side; the source/consumer takes master.
interface frame_parity_if #(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 8
);
  logic [W-1:0]     in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_sum;
  logic             out_par;
  logic [CNT_W-1:0] out_cnt;
  logic             out_ovf;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_par, out_cnt, out_ovf
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_par, out_cnt, out_ovf
  );
endinterface

// File: rtl/frame_parity.sv
// Frame checksum/parity accumulator: XORs a stream of W-bit words into a
// running checksum and a frame parity bit, presenting the result until taken.
module frame_parity #(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic odd,
  frame_parity_if.slave bus
);
  typedef enum logic {ACC, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [W-1:0]     sum_q;
  logic             par_q;
  logic             odd_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      ACC: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && bus.in_last) state_nxt = HOLD;
      end
      HOLD: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = ACC;
      end
      default: state_nxt = ACC;
    endcase
    if (clear) state_nxt = ACC;
  end

  assign accept = bus.in_valid & bus.in_ready;
  assign take   = bus.out_valid & bus.out_ready;

  // cnt never wraps back to zero, so cnt==0 marks the first word of a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      par_q <= 1'b0;
      odd_q <= 1'b0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else if (clear || take) begin
      sum_q <= '0;
      par_q <= 1'b0;
      odd_q <= 1'b0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else if (accept) begin
      sum_q <= sum_q ^ bus.in_data;
      par_q <= par_q ^ (^bus.in_data);
      if (cnt_q == '0) odd_q <= odd;
      if (cnt_q == CNT_MAX) ovf_q <= 1'b1;
      else                  cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.out_sum = sum_q;
  assign bus.out_par = par_q ^ odd_q;
  assign bus.out_cnt = cnt_q;
  assign bus.out_ovf = ovf_q;
endmodule
